// File: rtl/pwm_pulse_capture_pkg.sv
// Shared servo timing constants and capture FSM encoding for the PWM receive path.
package pwm_pulse_capture_pkg;

  localparam int PWM_CNT_W     = 20;
  localparam int CLK_HZ        = 25_000_000;
  localparam int CYC_PER_MS    = CLK_HZ / 1000;

  // Servo frame and the three canonical pulse widths, in i_Clk cycles.
  localparam int FRAME_CYC     = 20 * CYC_PER_MS;
  localparam int PULSE_1P0_CYC = CYC_PER_MS;
  localparam int PULSE_1P5_CYC = (3 * CYC_PER_MS) / 2;
  localparam int PULSE_2P0_CYC = 2 * CYC_PER_MS;

  // Loss-of-signal window: 30 ms without a rising edge.
  localparam int TIMEOUT_CYC   = 30 * CYC_PER_MS;

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM pin into i_Clk and detects its edges.
module pwm_edge_sync
  import pwm_pulse_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Pwm,
  output logic o_S,
  output logic o_Rise,
  output logic o_Fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchronizer chain and keep one cycle of history.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_Pwm};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_S    = r_sync[SYNC_STAGES-1];
  assign o_Rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_Fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/pwm_pulse_capture.sv
// Measures high time and rise-to-rise period of a PWM line; flags loss of signal.
module pwm_pulse_capture
  import pwm_pulse_capture_pkg::*;
#(
  parameter int          CNT_W       = PWM_CNT_W,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_CYC
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Pwm,
  output logic [CNT_W-1:0] o_Width,
  output logic [CNT_W-1:0] o_Period,
  output logic             o_Valid,
  output logic             o_Timeout
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Counters stick at all-ones so an over-long pulse never reads back as a short one.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_per_limit;
  cap_state_e       r_state;
  cap_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] w_hi_nxt;
  logic [CNT_W-1:0] w_per_nxt;
  logic             w_capture;
  logic             w_timeout_evt;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_Pwm (i_Pwm),
    .o_S   (w_s),
    .o_Rise(w_rise),
    .o_Fall(w_fall)
  );

  // Zero-extend before comparing so a TIMEOUT wider than the counter simply never fires.
  assign w_per_limit = (32'(r_per_cnt) >= TIMEOUT);

  // Next-state and counter update; a rise in S_LOW takes priority over the timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_hi_nxt      = r_hi_cnt;
    w_per_nxt     = r_per_cnt;
    w_capture     = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      S_ARM: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          w_hi_nxt    = CNT_ONE;
          w_per_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = S_ARM;
          w_hi_nxt    = CNT_ZERO;
          w_per_nxt   = CNT_ZERO;
        end
      end
      S_HIGH: begin
        if (w_per_limit) begin
          w_timeout_evt = 1'b1;
          w_state_nxt   = S_ARM;
          w_hi_nxt      = CNT_ZERO;
          w_per_nxt     = CNT_ZERO;
        end else begin
          w_per_nxt = sat_inc(r_per_cnt);
          if (w_s) begin
            w_hi_nxt = sat_inc(r_hi_cnt);
          end else begin
            w_hi_nxt = r_hi_cnt;
          end
          if (w_fall) begin
            w_state_nxt = S_LOW;
          end else begin
            w_state_nxt = S_HIGH;
          end
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HIGH;
          w_hi_nxt    = CNT_ONE;
          w_per_nxt   = CNT_ONE;
        end else if (w_per_limit) begin
          w_timeout_evt = 1'b1;
          w_state_nxt   = S_ARM;
          w_hi_nxt      = CNT_ZERO;
          w_per_nxt     = CNT_ZERO;
        end else begin
          w_per_nxt = sat_inc(r_per_cnt);
        end
      end
      default: begin
        w_state_nxt = S_ARM;
        w_hi_nxt    = CNT_ZERO;
        w_per_nxt   = CNT_ZERO;
      end
    endcase
  end

  // FSM state and measurement counters.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state   <= S_ARM;
      r_hi_cnt  <= CNT_ZERO;
      r_per_cnt <= CNT_ZERO;
    end else begin
      r_state   <= w_state_nxt;
      r_hi_cnt  <= w_hi_nxt;
      r_per_cnt <= w_per_nxt;
    end
  end

  // Published results: capture strobe, held measurement and sticky loss-of-signal flag.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_width   <= CNT_ZERO;
      r_period  <= CNT_ZERO;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_width   <= r_hi_cnt;
        r_period  <= r_per_cnt;
        r_timeout <= 1'b0;
      end else if (w_timeout_evt) begin
        r_timeout <= 1'b1;
      end else begin
        r_timeout <= r_timeout;
      end
    end
  end

  assign o_Width   = r_width;
  assign o_Period  = r_period;
  assign o_Valid   = r_valid;
  assign o_Timeout = r_timeout;

endmodule

// File: tb/tb_pwm_pulse_capture.sv
// Scoreboard bench for pwm_pulse_capture; servo timings scaled down by SCALE.
module tb_pwm_pulse_capture;
  import pwm_pulse_capture_pkg::*;

  localparam int SCALE = 200;
  localparam int FRAME = FRAME_CYC / SCALE;      // 2500
  localparam int H10   = PULSE_1P0_CYC / SCALE;  // 125
  localparam int H15   = PULSE_1P5_CYC / SCALE;  // 187
  localparam int H20   = PULSE_2P0_CYC / SCALE;  // 250
  localparam int TMO   = TIMEOUT_CYC / SCALE;    // 3750

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm;
  logic        pwm_b;
  logic [19:0] o_width, o_period;
  logic        o_valid, o_timeout;
  logic [7:0]  sat_w, sat_p, mx_w, mx_p;
  logic        sat_v, sat_to, mx_v, mx_to;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  typedef struct {
    longint w;
    longint p;
    longint c;
  } exp_t;
  exp_t sb_q[$];

  bit     armed  = 1'b0;
  longint last_h = 0;
  longint last_p = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pwm_pulse_capture #(.CNT_W(20), .SYNC_STAGES(2), .TIMEOUT(TMO)) u_dut (
    .i_Clk(clk), .i_Rst(rst), .i_Pwm(pwm),
    .o_Width(o_width), .o_Period(o_period), .o_Valid(o_valid), .o_Timeout(o_timeout)
  );

  // Counters can never reach 1000 in 8 bits: shows saturation without any timeout.
  pwm_pulse_capture #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(1000)) u_sat (
    .i_Clk(clk), .i_Rst(rst), .i_Pwm(pwm_b),
    .o_Width(sat_w), .o_Period(sat_p), .o_Valid(sat_v), .o_Timeout(sat_to)
  );

  // TIMEOUT equal to the counter all-ones value.
  pwm_pulse_capture #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(255)) u_max (
    .i_Clk(clk), .i_Rst(rst), .i_Pwm(pwm_b),
    .o_Width(mx_w), .o_Period(mx_p), .o_Valid(mx_v), .o_Timeout(mx_to)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One pulse: high for h clocks, rise-to-rise p clocks. Its rise reports the previous pulse.
  task automatic pulse(input int h, input int p);
    @(posedge clk);
    #1 pwm = 1'b1;
    if (armed) sb_q.push_back('{last_h, last_p, cyc + 3});
    armed  = 1'b1;
    last_h = h;
    last_p = p;
    repeat (h) @(posedge clk);
    #1 pwm = 1'b0;
    repeat (p - h - 1) @(posedge clk);
  endtask

  // Scoreboard: o_Valid must appear exactly on the predicted cycle and nowhere else.
  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    exp_v = (sb_q.size() > 0) && (sb_q[0].c == cyc);
    chk("valid_strobe", 64'(o_valid), 64'(exp_v));
    if (sb_q.size() > 0 && sb_q[0].c <= cyc) begin
      e = sb_q.pop_front();
      if (exp_v) begin
        chk("width", 64'(o_width), 64'(e.w));
        chk("period", 64'(o_period), 64'(e.p));
        chk("timeout_at_valid", 64'(o_timeout), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks run", n_tests);
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    pwm   = 1'b0;
    pwm_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_width", 64'(o_width), 64'd0);
    chk("rst_period", 64'(o_period), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    rst = 1'b0;

    // Nominal 1.5 ms frames: first pulse silent, then two reports.
    repeat (3) pulse(H15, FRAME);
    // Minimum legal pulse: 1-cycle high every 10 cycles.
    repeat (4) pulse(1, 10);
    // Period exactly TIMEOUT: the rise wins over the timeout.
    repeat (3) pulse(H10, TMO);
    chk("no_timeout_at_limit", 64'(o_timeout), 64'd0);

    // Line held low after the last pulse: loss of signal.
    for (int i = 0; i < 5000; i++) begin
      if (o_timeout) break;
      @(posedge clk);
    end
    #1;
    chk("timeout_set", 64'(o_timeout), 64'd1);
    chk("held_width", 64'(o_width), 64'(H10));
    chk("held_period", 64'(o_period), 64'(TMO));
    armed = 1'b0;
    pulse(H20, FRAME);
    chk("timeout_sticky", 64'(o_timeout), 64'd1);
    pulse(H20, FRAME);
    chk("timeout_cleared", 64'(o_timeout), 64'd0);
    pulse(H20, FRAME);

    // Reset during the high phase; pin falls while reset is held.
    @(posedge clk);
    #1 pwm = 1'b1;
    if (armed) sb_q.push_back('{last_h, last_p, cyc + 3});
    repeat (H15 - 3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_width", 64'(o_width), 64'd0);
    chk("midrst_period", 64'(o_period), 64'd0);
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_timeout", 64'(o_timeout), 64'd0);
    repeat (3) @(posedge clk);
    #1 pwm = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b0;
    repeat (50) @(posedge clk);
    pulse(H15, FRAME);
    pulse(H15, FRAME);

    // Line stuck high: 8-bit counters saturate, TIMEOUT=255 fires.
    @(posedge clk);
    #1 pwm_b = 1'b1;
    repeat (200) @(posedge clk);
    #1 chk("max_timeout_early", 64'(mx_to), 64'd0);
    repeat (100) @(posedge clk);
    #1 chk("max_timeout_set", 64'(mx_to), 64'd1);
    repeat (100) @(posedge clk);
    #1 pwm_b = 1'b0;
    repeat (20) @(posedge clk);
    #1 pwm_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_valid", 64'(sat_v), 64'd1);
    chk("sat_width", 64'(sat_w), 64'd255);
    chk("sat_period", 64'(sat_p), 64'd255);
    chk("sat_timeout", 64'(sat_to), 64'd0);
    chk("max_rearm_no_valid", 64'(mx_v), 64'd0);
    chk("max_timeout_held", 64'(mx_to), 64'd1);
    chk("max_width_zero", 64'(mx_w), 64'd0);
    @(negedge clk);
    chk("sat_valid_one_cycle", 64'(sat_v), 64'd0);
    pwm_b = 1'b0;

    repeat (10) @(posedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
